serial_sub_unit: RTL and testbench
==================================

// Module: serial_sub_unit
// PURPOSE
//  Multi-cycle, digit-serial WIDTH-bit subtractor with a start/done handshake.
//  Computes diff = a - b - borrow_in, DIGIT bits per clock, and reports flags.
//  Generalises the 1-bit half-subtractor cell to arbitrary width and throughput.
//  Serves as the area-lean subtract/compare path beside the MIPS ALU (SUB, SLT, BEQ).
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be >= 2
//  DIGIT  1   bits processed per cycle; must divide WIDTH (1,2,4,...,WIDTH)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous active-high reset
//  start       in   1      request; sampled only in IDLE or DONE
//  a           in   WIDTH  minuend, captured on accepted start
//  b           in   WIDTH  subtrahend, captured on accepted start
//  borrow_in   in   1      initial borrow, captured on accepted start
//  busy        out  1      high while a subtraction is in progress
//  done        out  1      one-cycle pulse; results valid from this cycle on
//  diff        out  WIDTH  a - b - borrow_in (mod 2^WIDTH)
//  borrow_out  out  1      unsigned borrow from the MSB (1 => a < b + borrow_in)
//  overflow    out  1      signed overflow of the two's-complement subtraction
//  zero        out  1      diff == 0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy, done, diff, borrow_out,
//    overflow and zero all 0; internal shift registers and the borrow flop cleared.
//  - FSM: IDLE --start--> RUN; RUN --last digit--> DONE; DONE --start--> RUN;
//    DONE --!start--> IDLE.
//  - Accepted start: latch a, b and borrow_in; set digit count = 0; busy=1 next cycle.
//  - RUN: each cycle subtract the low DIGIT bits of the a/b shift registers with the
//    borrow flop (ripple of DIGIT full-subtractor cells). Shift the result in at the
//    MSB end of the diff shift register, shift a/b right by DIGIT and update the borrow flop.
//  - Latency: done asserts exactly N=WIDTH/DIGIT cycles after the start-sampling edge.
//    busy is high for exactly those N cycles and low in the done cycle.
//  - Result outputs are registered and update only when done asserts. They hold
//    until the next done or reset.
//  - overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the captured operands.
//  - start while RUN is ignored (no restart, no queuing). Inputs a/b may change
//    freely after acceptance.
//  - start in the DONE cycle is accepted (back-to-back). Throughput is one op per N+1 cycles.
//  - Counter wraps only via FSM exit; it never counts past N-1.
//  - DIGIT==WIDTH degenerates to N=1: done one cycle after start.
//  - Reset mid-RUN aborts the operation; the outputs return to the 0 values above.
// STRUCTURE
//  - Shared header sub_defs.vh holds the FSM state encodings (S_IDLE=2'd0, S_RUN=2'd1,
//    S_DONE=2'd2) and a clog2-style count-width macro.
//  - One sub-module, sub_digit #(DIGIT): combinational ripple-borrow subtractor
//    with ports x[DIGIT], y[DIGIT], bin -> d[DIGIT], bout. Each bit is a full
//    subtractor built from two half-subtractor stages (d = x^y^bin,
//    bout = (~x&y) | (~(x^y)&bin)).
//  - Top holds the FSM, counter, operand/result shift registers and flag logic.
// TESTING (WIDTH=8 unless stated)
//  1. DIGIT=1, a=8'd5, b=8'd3, bin=0 -> done 8 cycles after start; diff=8'h02,
//     borrow_out=0, overflow=0, zero=0.
//  2. a=8'd3, b=8'd5 -> diff=8'hFE, borrow_out=1, overflow=0; a=8'h80, b=8'h01
//     -> diff=8'h7F, overflow=1, borrow_out=0.
//  3. a=b=8'hA5, bin=0 -> diff=0, zero=1. a=8'h00, b=8'h00, bin=1 -> diff=8'hFF,
//     borrow_out=1, zero=0.
//  4. Start pulsed again mid-RUN with different operands -> ignored; done at the
//     original cycle with the original result. Start held in the DONE cycle -> new
//     op accepted, next done N+1 cycles after the previous one.
//  5. Assert rst at cycle 4 of RUN -> busy/done/diff/flags = 0 immediately (async).
//     The next start runs a full N cycles with the correct result.
//  6. DIGIT=4 and DIGIT=8 builds: random a/b/bin sweep (>=1000 ops) vs
//     reference a-b-bin -> latency 2 and 1 cycles respectively, all outputs match.

Source files
------------

// File: rtl/serial_sub_unit_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_t   : FSM state encoding (IDLE / RUN / DONE)
//   cnt_width : width of a counter that must hold 0..n-1 (at least 1 bit)
package serial_sub_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sub_unit_sub_digit.sv
// sub_digit: combinational ripple-borrow subtractor for one DIGIT-bit digit.
//   x, y : minuend / subtrahend digit
//   bin  : incoming borrow
//   d    : x - y - bin (mod 2^DIGIT)
//   bout : borrow out of the digit MSB
// Each bit is a full subtractor made of two half-subtractor stages.
module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] c;

    assign c[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        logic h1, b1, b2;
        // first stage: x - y
        assign h1 = x[i] ^ y[i];
        assign b1 = ~x[i] & y[i];
        // second stage: (x - y) - borrow
        assign d[i]   = h1 ^ c[i];
        assign b2     = ~h1 & c[i];
        assign c[i+1] = b1 | b2;
    end

    assign bout = c[DIGIT];

endmodule

// File: rtl/serial_sub_unit.sv
// serial_sub_unit: multi-cycle digit-serial subtractor, diff = a - b - borrow_in.
//   clk, rst           : clock, async active-high reset
//   start              : request, taken in IDLE or DONE
//   a, b, borrow_in    : operands, captured on an accepted start
//   busy               : high for the N = WIDTH/DIGIT working cycles
//   done               : one-cycle pulse, results valid from this cycle on
//   diff, borrow_out,
//   overflow, zero     : registered results, held until next done or reset
module serial_sub_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);
    import serial_sub_unit_pkg::*;

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_nxt;
    logic             borrow_q;
    logic             a_msb, b_msb;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dig_d;
    logic             dig_bout;
    logic             accept, last;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (a_sh[DIGIT-1:0]),
        .y    (b_sh[DIGIT-1:0]),
        .bin  (borrow_q),
        .d    (dig_d),
        .bout (dig_bout)
    );

    // New digit enters at the MSB end; after N shifts the LSB digit has
    // reached bit 0.
    if (DIGIT == WIDTH) begin : g_full
        assign d_nxt = dig_d;
    end else begin : g_part
        assign d_nxt = {dig_d, d_sh[WIDTH-1:DIGIT]};
    end

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = (state == S_RUN) && (cnt == CW'(N - 1));
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            borrow_q <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            a_sh     <= a;
            b_sh     <= b;
            d_sh     <= '0;
            borrow_q <= borrow_in;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            cnt      <= '0;
        end else if (state == S_RUN) begin
            a_sh     <= a_sh >> DIGIT;
            b_sh     <= b_sh >> DIGIT;
            d_sh     <= d_nxt;
            borrow_q <= dig_bout;
            // hold at N-1; the next accept reloads it
            if (!last) cnt <= cnt + CW'(1);
        end
    end

    // Results are taken straight from the final digit so they appear
    // together with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else if (last) begin
            diff       <= d_nxt;
            borrow_out <= dig_bout;
            overflow   <= (a_msb != b_msb) && (d_nxt[WIDTH-1] != a_msb);
            zero       <= (d_nxt == '0);
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Bench for serial_sub_unit: three WIDTH=8 instances (DIGIT = 1, 4, 8)
// sharing clock, reset and operands, each with its own start.
module tb_serial_sub_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       bin = 1'b0;

    logic       busy1, done1, bo1, ov1, z1;
    logic       busy4, done4, bo4, ov4, z4;
    logic       busy8, done8, bo8, ov8, z8;
    logic [7:0] diff1, diff4, diff8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub_unit #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .borrow_in(bin),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1),
        .overflow(ov1), .zero(z1));
    serial_sub_unit #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .borrow_in(bin),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4),
        .overflow(ov4), .zero(z4));
    serial_sub_unit #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .borrow_in(bin),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8),
        .overflow(ov8), .zero(z8));

    // Reference: {borrow, overflow, zero, diff} from plain integer arithmetic.
    function automatic logic [10:0] ref_sub(input logic [7:0] x, input logic [7:0] y,
                                            input logic bi);
        int u, s;
        logic [7:0] d;
        u = int'(x) - int'(y) - int'(bi);
        s = int'($signed(x)) - int'($signed(y)) - int'(bi);
        d = 8'(u);
        return {u < 0, (s < -128) || (s > 127), d == 8'h00, d};
    endfunction

    // Start an op on dut1 at the current negedge and wait for done.
    // poke_at >= 0 pulses start with other operands at that RUN cycle.
    task automatic run1(input logic [7:0] x, input logic [7:0] y, input logic bi,
                        input int poke_at, output int lat);
        a = x; b = y; bin = bi; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got=%b want=1", busy1);
        end
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            start1 = 1'b0;
            if (done1) break;
            if (lat == poke_at) begin
                a = 8'h11; b = 8'h22; bin = 1'b1; start1 = 1'b1;
            end
        end
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL done_wait got done=%b busy=%b after %0d cycles want done=1 busy=0",
                     done1, busy1, lat);
        end
    endtask

    task automatic check1(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic bi, input int lat);
        logic [10:0] exp;
        exp = ref_sub(x, y, bi);
        checks++;
        if ({bo1, ov1, z1, diff1} !== exp || lat != 8) begin
            failures++;
            $display("FAIL %s got bo=%b ov=%b z=%b diff=%h lat=%0d want bo=%b ov=%b z=%b diff=%h lat=8",
                     name, bo1, ov1, z1, diff1, lat, exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy1, done1, diff1, bo1, ov1, z1} !== 12'h0 ||
            {busy4, done4, diff4, bo4, ov4, z4} !== 12'h0 ||
            {busy8, done8, diff8, bo8, ov8, z8} !== 12'h0) begin
            failures++;
            $display("FAIL reset_state got d1=%h d4=%h d8=%h want all 0",
                     {busy1, done1, diff1, bo1, ov1, z1},
                     {busy4, done4, diff4, bo4, ov4, z4},
                     {busy8, done8, diff8, bo8, ov8, z8});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        int lat;
        // exact spec vectors, expectations written as constants
        run1(8'd5, 8'd3, 1'b0, -1, lat);
        checks++;
        if ({diff1, bo1, ov1, z1} !== {8'h02, 3'b000} || lat != 8) begin
            failures++;
            $display("FAIL vec_5_3 got diff=%h bo=%b ov=%b z=%b lat=%0d want 02 0 0 0 lat=8",
                     diff1, bo1, ov1, z1, lat);
        end
        run1(8'd3, 8'd5, 1'b0, -1, lat);
        checks++;
        if ({diff1, bo1, ov1, z1} !== {8'hFE, 3'b100}) begin
            failures++;
            $display("FAIL vec_3_5 got diff=%h bo=%b ov=%b z=%b want FE 1 0 0",
                     diff1, bo1, ov1, z1);
        end
        run1(8'h80, 8'h01, 1'b0, -1, lat);
        checks++;
        if ({diff1, bo1, ov1, z1} !== {8'h7F, 3'b010}) begin
            failures++;
            $display("FAIL vec_80_01 got diff=%h bo=%b ov=%b z=%b want 7F 0 1 0",
                     diff1, bo1, ov1, z1);
        end
        run1(8'hA5, 8'hA5, 1'b0, -1, lat);
        checks++;
        if ({diff1, bo1, ov1, z1} !== {8'h00, 3'b001}) begin
            failures++;
            $display("FAIL vec_eq got diff=%h bo=%b ov=%b z=%b want 00 0 0 1",
                     diff1, bo1, ov1, z1);
        end
        run1(8'h00, 8'h00, 1'b1, -1, lat);
        checks++;
        if ({diff1, bo1, ov1, z1} !== {8'hFF, 3'b100}) begin
            failures++;
            $display("FAIL vec_bin got diff=%h bo=%b ov=%b z=%b want FF 1 0 0",
                     diff1, bo1, ov1, z1);
        end
        // results must hold after done
        repeat (3) @(negedge clk);
        checks++;
        if (diff1 !== 8'hFF || bo1 !== 1'b1 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL hold got diff=%h bo=%b done=%b want FF 1 0", diff1, bo1, done1);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        run1(8'h3C, 8'h0F, 1'b0, 3, lat);
        check1("ignore_mid_start", 8'h3C, 8'h0F, 1'b0, lat);
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL no_restart got busy=%b done=%b want 0 0", busy1, done1);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run1(8'h10, 8'h20, 1'b1, -1, lat);
        check1("b2b_first", 8'h10, 8'h20, 1'b1, lat);
        // start issued in the done cycle: next done lands N+1 after this one
        run1(8'h80, 8'h01, 1'b0, -1, lat);
        check1("b2b_second", 8'h80, 8'h01, 1'b0, lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        a = 8'hF0; b = 8'h0E; bin = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy1, done1, diff1, bo1, ov1, z1} !== 12'h0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b diff=%h bo=%b ov=%b z=%b want all 0",
                     busy1, done1, diff1, bo1, ov1, z1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run1(8'hC3, 8'h5A, 1'b1, -1, lat);
        check1("after_reset", 8'hC3, 8'h5A, 1'b1, lat);
    endtask

    task automatic test_random1();
        int lat;
        logic [7:0] x, y;
        logic bi;
        for (int i = 0; i < 100; i++) begin
            x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
            run1(x, y, bi, -1, lat);
            check1("rand_d1", x, y, bi, lat);
            @(negedge clk);
        end
    endtask

    task automatic test_sweep_d4_d8();
        logic [10:0] exp;
        int c, got4, got8;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            if (i < 4) begin
                a = (i < 2) ? 8'h00 : 8'hFF;
                b = (i[0]) ? 8'hFF : 8'h00;
            end
            exp = ref_sub(a, b, bin);
            start4 = 1'b1; start8 = 1'b1;
            @(negedge clk);
            start4 = 1'b0; start8 = 1'b0;
            got4 = -1; got8 = -1;
            for (c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (done4 && got4 < 0) begin
                    got4 = c;
                    checks++;
                    if ({bo4, ov4, z4, diff4} !== exp) begin
                        failures++;
                        $display("FAIL sweep_d4 a=%h b=%h bin=%b got %h want %h",
                                 a, b, bin, {bo4, ov4, z4, diff4}, exp);
                    end
                end
                if (done8 && got8 < 0) begin
                    got8 = c;
                    checks++;
                    if ({bo8, ov8, z8, diff8} !== exp) begin
                        failures++;
                        $display("FAIL sweep_d8 a=%h b=%h bin=%b got %h want %h",
                                 a, b, bin, {bo8, ov8, z8, diff8}, exp);
                    end
                end
            end
            checks++;
            if (got4 != 2 || got8 != 1) begin
                failures++;
                $display("FAIL sweep_latency got d4=%0d d8=%0d want 2 1", got4, got8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random1();
        test_sweep_d4_d8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
